// File: rtl/fifo_rd_stream_if.sv
// FIFO read port and framed output stream of fifo_rd_stream.
// The master modport is the consumer block; slave is the FIFO plus downstream sink.
interface fifo_rd_stream_if #(
    parameter int DATA_W = 8
);
    logic              fifo_empty;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        input  fifo_empty, fifo_data, out_ready,
        output fifo_pop, out_valid, out_data, out_last
    );

    modport slave (
        output fifo_empty, fifo_data, out_ready,
        input  fifo_pop, out_valid, out_data, out_last
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-domain FIFO consumer: pops words into a 2-entry skid buffer and emits a BURST_LEN-framed valid/ready stream.
// Defining FIFO_RD_STATS_EN adds word_cnt (transfers) and stall_cnt (saturating stall cycles) outputs.
module fifo_rd_stream #(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4
) (
    input  logic             rdclk,
    input  logic             rd_rst,
    input  logic             en,
    fifo_rd_stream_if.master bus,
    output logic             busy
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [31:0]      word_cnt,
    output logic [15:0]      stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

    state_t            state_q, state_d;
    logic [1:0]        occ_q, occ_d;
    logic              inflight_q;
    logic [7:0]        beat_q, beat_d;
    logic              head_q, head_d;
    logic [DATA_W-1:0] buf_q [2];

    logic              valid_s;
    logic              xfer_s;
    logic              pop_s;
    logic              tail_s;
    logic [2:0]        level_s;

    // Buffer level after this cycle's capture and transfer decides whether one more pop still fits.
    always_comb begin
        valid_s = (occ_q != 2'd0);
        xfer_s  = valid_s && bus.out_ready;
        level_s = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, xfer_s};
        pop_s   = (state_q == RUN) && !bus.fifo_empty && (level_s < 3'd2);
        occ_d   = level_s[1:0];
        tail_s  = head_q ^ occ_q[0];
        if (xfer_s) begin
            head_d = ~head_q;
            if (beat_q == LAST_BEAT) begin
                beat_d = 8'd0;
            end else begin
                beat_d = beat_q + 8'd1;
            end
        end else begin
            head_d = head_q;
            beat_d = beat_q;
        end
    end

    // Pop enable state: STOP waits for the in-flight word and the buffer to drain before leaving.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (!en) begin
                    state_d = STOP;
                end else begin
                    state_d = RUN;
                end
            end
            STOP: begin
                if (!inflight_q && (occ_q == 2'd0)) begin
                    if (en) begin
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = STOP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state registers.
    always_ff @(posedge rdclk or posedge rd_rst) begin
        if (rd_rst) begin
            state_q    <= IDLE;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            beat_q     <= 8'd0;
            head_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            inflight_q <= pop_s;
            beat_q     <= beat_d;
            head_q     <= head_d;
        end
    end

    // Skid buffer: the word returned one cycle after a pop lands at the tail.
    always_ff @(posedge rdclk or posedge rd_rst) begin
        if (rd_rst) begin
            buf_q[0] <= {DATA_W{1'b0}};
            buf_q[1] <= {DATA_W{1'b0}};
        end else if (inflight_q) begin
            buf_q[tail_s] <= bus.fifo_data;
        end
    end

    assign bus.fifo_pop  = pop_s;
    assign bus.out_valid = valid_s;
    assign bus.out_data  = buf_q[head_q];
    assign bus.out_last  = valid_s && (beat_q == LAST_BEAT);
    assign busy          = (state_q != IDLE);

`ifdef FIFO_RD_STATS_EN
    logic [31:0] word_cnt_q;
    logic [15:0] stall_cnt_q;

    // Transfer counter wraps; stall counter sticks at its maximum.
    always_ff @(posedge rdclk or posedge rd_rst) begin
        if (rd_rst) begin
            word_cnt_q  <= 32'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            if (xfer_s) begin
                word_cnt_q <= word_cnt_q + 32'd1;
            end
            if (valid_s && !bus.out_ready && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign word_cnt  = word_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: a FIFO model feeds two instances (BURST_LEN 4 and 1),
// popped words are queued as expectations and compared when the stream transfers them.
module tb_fifo_rd_stream;
    localparam int DATA_W = 8;

    logic              rdclk = 1'b0;
    logic              rd_rst, en, sel, out_ready;
    logic              busy0, busy1;
    logic [DATA_W-1:0] fmem [256];
    logic [7:0]        wr_idx = 8'd0;
    logic [7:0]        rd_idx = 8'd0;
    logic [DATA_W-1:0] fifo_data = 8'h00;
    logic              fifo_empty, pop_any, en0, en1;
    logic              m_valid, m_last, m_busy;
    logic [DATA_W-1:0] m_data;
`ifdef FIFO_RD_STATS_EN
    logic [31:0]       word_cnt1;
    logic [15:0]       stall_cnt1;
`endif

    int                checks = 0;
    int                errors = 0;
    logic [DATA_W-1:0] exp_q [$];
    int                mbeat = 0;
    int                outstanding = 0;
    int                xfer_cnt = 0;
    int                last_cnt = 0;
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data = 8'h00;
    logic              prev_last = 1'b0;
    logic [DATA_W-1:0] last_flag_data = 8'h00;

    fifo_rd_stream_if #(.DATA_W(DATA_W)) if0 ();
    fifo_rd_stream_if #(.DATA_W(DATA_W)) if1 ();

    assign fifo_empty     = (rd_idx == wr_idx);
    assign pop_any        = if0.fifo_pop | if1.fifo_pop;
    assign en0            = en & ~sel;
    assign en1            = en & sel;
    assign if0.fifo_empty = fifo_empty;
    assign if0.fifo_data  = fifo_data;
    assign if0.out_ready  = out_ready;
    assign if1.fifo_empty = fifo_empty;
    assign if1.fifo_data  = fifo_data;
    assign if1.out_ready  = out_ready;
    assign m_valid        = sel ? if1.out_valid : if0.out_valid;
    assign m_data         = sel ? if1.out_data  : if0.out_data;
    assign m_last         = sel ? if1.out_last  : if0.out_last;
    assign m_busy         = sel ? busy1 : busy0;

    fifo_rd_stream #(.DATA_W(DATA_W), .BURST_LEN(4)) u_dut0 (
        .rdclk  (rdclk),
        .rd_rst (rd_rst),
        .en     (en0),
        .bus    (if0),
        .busy   (busy0)
    );

    fifo_rd_stream #(.DATA_W(DATA_W), .BURST_LEN(1)) u_dut1 (
        .rdclk  (rdclk),
        .rd_rst (rd_rst),
        .en     (en1),
        .bus    (if1),
        .busy   (busy1)
`ifdef FIFO_RD_STATS_EN
        ,
        .word_cnt  (word_cnt1),
        .stall_cnt (stall_cnt1)
`endif
    );

    always #5 rdclk = ~rdclk;

    // FIFO model: read data appears the cycle after a pop
    always @(posedge rdclk) begin
        if (pop_any) begin
            fifo_data <= fmem[rd_idx];
            rd_idx    <= rd_idx + 8'd1;
        end
    end

    // Stream monitor and scoreboard
    always @(negedge rdclk) begin : mon
        int                bl;
        logic              exp_last;
        logic [DATA_W-1:0] exp_d;
        bl = sel ? 1 : 4;
        if (rd_rst) begin
            exp_q.delete();
            mbeat       = 0;
            outstanding = 0;
            prev_stall  = 1'b0;
        end else begin
            if (pop_any) begin
                checks++;
                if (fifo_empty !== 1'b0) begin
                    errors++;
                    $display("FAIL pop_while_empty: fifo_empty=%b required 0", fifo_empty);
                end
                exp_q.push_back(fmem[rd_idx]);
            end
            if (prev_stall) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last) begin
                    errors++;
                    $display("FAIL hold: got v=%b d=%h l=%b required v=1 d=%h l=%b",
                             m_valid, m_data, m_last, prev_data, prev_last);
                end
            end
            if (m_valid && out_ready) begin
                exp_last = (mbeat == bl - 1);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: got %h required no transfer", m_data);
                end else begin
                    exp_d = exp_q.pop_front();
                    if (m_data !== exp_d || m_last !== exp_last) begin
                        errors++;
                        $display("FAIL stream_word: got d=%h l=%b required d=%h l=%b",
                                 m_data, m_last, exp_d, exp_last);
                    end
                end
                mbeat = (mbeat == bl - 1) ? 0 : mbeat + 1;
                xfer_cnt++;
                if (m_last) begin
                    last_cnt++;
                    last_flag_data = m_data;
                end
            end
            outstanding = outstanding + (pop_any ? 1 : 0) - ((m_valid && out_ready) ? 1 : 0);
            if (outstanding > 2) begin
                checks++;
                errors++;
                $display("FAIL occupancy: got %0d required <= 2", outstanding);
            end
            prev_stall = m_valid && !out_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge rdclk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        fmem[wr_idx] = d;
        wr_idx = wr_idx + 8'd1;
    endtask

    task automatic apply_reset();
        @(posedge rdclk);
        #1;
        rd_rst    = 1'b1;
        en        = 1'b0;
        out_ready = 1'b1;
        tick(2);
        rd_rst = 1'b0;
    endtask

    // Lets the stream empty everything popped, then drops en and waits for IDLE.
    task automatic drain(output logic ok);
        logic got;
        out_ready = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge rdclk);
            #1;
            if (fifo_empty && exp_q.size() == 0 && !m_valid && !pop_any) begin
                got = 1'b1;
                break;
            end
        end
        if (got) begin
            @(posedge rdclk);
            #1;
            en  = 1'b0;
            got = 1'b0;
            for (int t = 0; t < 20; t++) begin
                @(negedge rdclk);
                if (!m_busy) begin
                    got = 1'b1;
                    break;
                end
            end
        end
        ok = got;
    endtask

    task automatic test_reset();
        @(negedge rdclk);
        checks++;
        if ({if0.fifo_pop, if0.out_valid, if0.out_last, busy0,
             if1.fifo_pop, if1.out_valid, if1.out_last, busy1} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 00000000",
                     {if0.fifo_pop, if0.out_valid, if0.out_last, busy0,
                      if1.fifo_pop, if1.out_valid, if1.out_last, busy1});
        end
        checks++;
        if (if0.out_data !== 8'h00 || if1.out_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: got %h/%h required 00/00", if0.out_data, if1.out_data);
        end
    endtask

    task automatic test_stream();
        int                pcnt, vcnt, pfirst, plast, vfirst, vlast;
        logic [DATA_W-1:0] seen_d [8];
        logic              seen_l [8];
        logic              ok;
        pcnt = 0; vcnt = 0; pfirst = 0; plast = 0; vfirst = 0; vlast = 0;
        apply_reset();
        for (int i = 0; i < 8; i++) push(8'(i));
        out_ready = 1'b1;
        en        = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge rdclk);
            if (if0.fifo_pop) begin
                if (pcnt == 0) pfirst = c;
                plast = c;
                pcnt++;
            end
            if (if0.out_valid) begin
                if (vcnt < 8) begin
                    seen_d[vcnt] = if0.out_data;
                    seen_l[vcnt] = if0.out_last;
                end
                if (vcnt == 0) vfirst = c;
                vlast = c;
                vcnt++;
            end
        end
        checks++;
        if (pcnt != 8 || plast - pfirst != 7) begin
            errors++;
            $display("FAIL stream_pops: got %0d pops over %0d cycles required 8 over 8", pcnt, plast - pfirst + 1);
        end
        checks++;
        if (vcnt != 8 || vlast - vfirst != 7) begin
            errors++;
            $display("FAIL stream_valid: got %0d words over %0d cycles required 8 over 8", vcnt, vlast - vfirst + 1);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (seen_d[k] !== 8'(k) || seen_l[k] !== ((k == 3) || (k == 7))) begin
                errors++;
                $display("FAIL stream_seq[%0d]: got d=%h l=%b required d=%h l=%b",
                         k, seen_d[k], seen_l[k], 8'(k), ((k == 3) || (k == 7)));
            end
        end
        drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stream_drain: got timeout required idle");
        end
    endtask

    task automatic test_backpressure();
        int   pops, x0;
        logic ok;
        apply_reset();
        x0 = xfer_cnt;
        for (int i = 0; i < 6; i++) push(8'(16 + i));
        out_ready = 1'b0;
        en        = 1'b1;
        pops = 0;
        ok   = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge rdclk);
            if (if0.fifo_pop) pops++;
            if (if0.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_first_valid: got timeout required out_valid");
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge rdclk);
            if (if0.fifo_pop) pops++;
        end
        #1;
        checks++;
        if (pops != 2 || outstanding != 2) begin
            errors++;
            $display("FAIL bp_pops: got pops=%0d occ=%0d required pops=2 occ=2", pops, outstanding);
        end
        checks++;
        if (if0.out_valid !== 1'b1 || if0.out_data !== 8'h10) begin
            errors++;
            $display("FAIL bp_head: got v=%b d=%h required v=1 d=10", if0.out_valid, if0.out_data);
        end
        @(posedge rdclk);
        #1;
        drain(ok);
        checks++;
        if (!ok || xfer_cnt - x0 != 6) begin
            errors++;
            $display("FAIL bp_delivered: got %0d words required 6", xfer_cnt - x0);
        end
    endtask

    task automatic test_empty_gap();
        int   x0, l0;
        logic ok;
        apply_reset();
        x0 = xfer_cnt;
        l0 = last_cnt;
        push(8'h20);
        push(8'h21);
        out_ready = 1'b1;
        en        = 1'b1;
        tick(8);
        for (int c = 0; c < 5; c++) begin
            @(negedge rdclk);
            checks++;
            if (if0.out_valid !== 1'b0 || if0.fifo_pop !== 1'b0) begin
                errors++;
                $display("FAIL gap_idle: got v=%b pop=%b required 0 0", if0.out_valid, if0.fifo_pop);
            end
        end
        @(posedge rdclk);
        #1;
        push(8'h22);
        push(8'h23);
        drain(ok);
        checks++;
        if (!ok || xfer_cnt - x0 != 4 || last_cnt - l0 != 1 || last_flag_data !== 8'h23) begin
            errors++;
            $display("FAIL gap_frame: got words=%0d lasts=%0d last_on=%h required 4 1 23",
                     xfer_cnt - x0, last_cnt - l0, last_flag_data);
        end
    endtask

    task automatic test_en_drop();
        int   x0, l0, pops, nx, xc, bc;
        logic ok;
        apply_reset();
        x0 = xfer_cnt;
        l0 = last_cnt;
        for (int i = 0; i < 4; i++) push(8'(64 + i));
        out_ready = 1'b1;
        en        = 1'b1;
        ok        = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge rdclk);
            if (if0.fifo_pop) begin
                ok = 1'b1;
                break;
            end
        end
        en = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drop_first_pop: got timeout required fifo_pop");
        end
        pops = 1; nx = 0; xc = -10; bc = -1;
        for (int c = 1; c < 16; c++) begin
            @(negedge rdclk);
            if (if0.fifo_pop) pops++;
            if (if0.out_valid && out_ready) begin
                nx++;
                xc = c;
            end
            if (!busy0 && bc < 0) bc = c;
        end
        checks++;
        if (pops != 1 || nx != 1) begin
            errors++;
            $display("FAIL drop_inflight: got pops=%0d words=%0d required 1 1", pops, nx);
        end
        checks++;
        if (bc - xc != 2) begin
            errors++;
            $display("FAIL drop_busy: got busy low %0d cycles after transfer required 2", bc - xc);
        end
        @(posedge rdclk);
        #1;
        en = 1'b1;
        drain(ok);
        checks++;
        if (!ok || xfer_cnt - x0 != 4 || last_cnt - l0 != 1 || last_flag_data !== 8'h43) begin
            errors++;
            $display("FAIL drop_resume: got words=%0d lasts=%0d last_on=%h required 4 1 43",
                     xfer_cnt - x0, last_cnt - l0, last_flag_data);
        end
    endtask

    task automatic test_reset_mid();
        int   x0;
        logic ok;
        apply_reset();
        for (int i = 0; i < 8; i++) push(8'(80 + i));
        out_ready = 1'b0;
        en        = 1'b1;
        tick(4);
        @(negedge rdclk);
        checks++;
        if (if0.out_valid !== 1'b1 || if0.out_data !== 8'h50) begin
            errors++;
            $display("FAIL rstmid_pre: got v=%b d=%h required v=1 d=50", if0.out_valid, if0.out_data);
        end
        @(posedge rdclk);
        #1;
        rd_rst = 1'b1;
        #1;
        checks++;
        if ({if0.fifo_pop, if0.out_valid, if0.out_last, busy0} !== 4'h0 || if0.out_data !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_outputs: got ctrl=%b d=%h required 0000 00",
                     {if0.fifo_pop, if0.out_valid, if0.out_last, busy0}, if0.out_data);
        end
        tick(2);
        rd_rst    = 1'b0;
        out_ready = 1'b1;
        x0        = xfer_cnt;
        ok        = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge rdclk);
            if (if0.out_valid && out_ready) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || if0.out_data !== 8'h52 || if0.out_last !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_first: got ok=%b d=%h l=%b required ok=1 d=52 l=0",
                     ok, if0.out_data, if0.out_last);
        end
        drain(ok);
        checks++;
        if (!ok || xfer_cnt - x0 != 6) begin
            errors++;
            $display("FAIL rstmid_rest: got %0d words required 6", xfer_cnt - x0);
        end
    endtask

    task automatic test_burst1_stats();
        int   x0, l0;
        logic ok;
        @(posedge rdclk);
        #1;
        sel = 1'b1;
        apply_reset();
        x0 = xfer_cnt;
        l0 = last_cnt;
        for (int i = 0; i < 3; i++) push(8'(96 + i));
        out_ready = 1'b0;
        en        = 1'b1;
        ok        = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge rdclk);
            if (if1.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b1_first_valid: got timeout required out_valid");
        end
        tick(4);
        out_ready = 1'b1;
        drain(ok);
        checks++;
        if (!ok || xfer_cnt - x0 != 3 || last_cnt - l0 != 3) begin
            errors++;
            $display("FAIL b1_lasts: got words=%0d lasts=%0d required 3 3", xfer_cnt - x0, last_cnt - l0);
        end
`ifdef FIFO_RD_STATS_EN
        checks++;
        if (word_cnt1 !== 32'd3 || stall_cnt1 !== 16'd4) begin
            errors++;
            $display("FAIL b1_stats: got word_cnt=%0d stall_cnt=%0d required 3 4", word_cnt1, stall_cnt1);
        end
`endif
    endtask

    initial begin
        rd_rst    = 1'b1;
        en        = 1'b0;
        sel       = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_stream();
        test_backpressure();
        test_empty_gap();
        test_en_drop();
        test_reset_mid();
        test_burst1_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
